mouse_click_cmd: RTL and testbench

Downstream of the PS/2 mouse interface. Turns its cursor position and button levels (`ArrowPosX/Y`, `left`, `right`, `GameArea`, `retract`, `retry`) into discrete, debounced game commands for the Sokoban game logic:

- move-to-tile
- undo
- restart
- cancel

Commands are buffered in a small FIFO and delivered over a valid/ready handshake.

---
 rtl/mouse_cmd_pkg.sv | 33 +++
 rtl/mouse_cmd_fifo.sv | 101 ++++++++++
 rtl/mouse_click_cmd.sv | 259 +++++++++++++++++++++++++
 tb/tb_mouse_click_cmd.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_cmd_pkg.sv
`default_nettype none
//==============================================================================
// Package  : mouse_cmd_pkg
// Purpose  : Shared definitions for the mouse click-to-command path.
//            Holds the command codes, the click FSM state encoding and
//            the packing helper for the 10-bit command record
//            {code[1:0], tile_x[3:0], tile_y[3:0]}.
// Revision : 1.0 - initial release
//==============================================================================
package mouse_cmd_pkg;

    localparam int c_CMD_W = 10;

    localparam logic [1:0] CMD_MOVE    = 2'd0;
    localparam logic [1:0] CMD_UNDO    = 2'd1;
    localparam logic [1:0] CMD_RESTART = 2'd2;
    localparam logic [1:0] CMD_CANCEL  = 2'd3;

    localparam int c_ST_W = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_HOLD = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_LOCK = 2'd2;

    function automatic logic [c_CMD_W-1:0] pack_cmd(
        input logic [1:0] code,
        input logic [3:0] tile_x,
        input logic [3:0] tile_y
    );
        return {code, tile_x, tile_y};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mouse_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module   : mouse_cmd_fifo
// Purpose  : Synchronous FIFO with a registered head entry. The head
//            register is the visible output; the remaining entries live
//            in a small backing ring. A write into an empty FIFO goes
//            straight into the head register.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_wr_en/i_wr_data - push request and data (ignored when full
//                                unless a pop happens in the same cycle)
//            i_rd_en          - pop the head when it is valid
//            o_rd_data        - head entry
//            o_full, o_empty  - occupancy flags (o_empty = head not valid)
// Revision : 1.0 - initial release
//==============================================================================
module mouse_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;      // total entries, head included
    logic [WIDTH-1:0] r_head;
    logic             r_head_valid;

    logic w_full;
    logic w_deq;
    logic w_wr_ok;
    logic w_back_nz;
    logic w_refill;
    logic w_pop;
    logic w_bypass;
    logic w_push;

    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_deq     = i_rd_en & r_head_valid;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_wr_ok   = i_wr_en & (~w_full | w_deq);
    // Backing ring holds everything except the head entry.
    assign w_back_nz = (r_count > {{(c_CW-1){1'b0}}, r_head_valid});
    assign w_refill  = ~r_head_valid | w_deq;
    assign w_pop     = w_refill & w_back_nz;
    assign w_bypass  = w_refill & ~w_back_nz & w_wr_ok;
    assign w_push    = w_wr_ok & ~w_bypass;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_refill) begin
                if (w_pop) begin
                    r_head       <= r_mem[r_rptr];
                    r_head_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_head       <= i_wr_data;
                    r_head_valid <= 1'b1;
                end else begin
                    r_head       <= '0;
                    r_head_valid <= 1'b0;
                end
            end
            r_count <= r_count + c_CW'(w_wr_ok) - c_CW'(w_deq);
        end
    end

    assign o_rd_data = r_head;
    assign o_full    = w_full;
    assign o_empty   = ~r_head_valid;

endmodule
`default_nettype wire

// File: rtl/mouse_click_cmd.sv
`default_nettype none
//==============================================================================
// Module   : mouse_click_cmd
// Purpose  : Converts PS/2 mouse cursor position and button levels into
//            debounced Sokoban commands (MOVE / UNDO / RESTART / CANCEL),
//            buffered in a small FIFO behind a valid/ready handshake.
// Ports    : sys_clk, reset         - clock, synchronous active-high reset
//            ArrowPosX, ArrowPosY   - cursor pixel position
//            left, right            - button levels
//            GameArea, retract, retry - cursor region flags
//            cmd_valid/cmd_ready    - output handshake (FIFO head)
//            cmd_code, cmd_tile_x, cmd_tile_y - command record
//            drop_cnt               - saturating count of dropped commands
// Config   : CLICK_REPEAT_EN - when defined, a held left button on a MOVE
//            re-issues MOVE to the current tile every REPEAT_CYCLES.
// Revision : 1.0 - initial release
//==============================================================================
module mouse_click_cmd
    import mouse_cmd_pkg::*;
#(
    parameter logic [9:0] ORIGIN_X       = 10'd64,
    parameter logic [9:0] ORIGIN_Y       = 10'd32,
    parameter int         TILE_SHIFT     = 5,
    parameter int         GRID_W         = 12,
    parameter int         GRID_H         = 12,
    parameter int         HOLDOFF_CYCLES = 500000,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         REPEAT_CYCLES  = 25000000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [9:0] ArrowPosX,
    input  logic [9:0] ArrowPosY,
    input  logic       left,
    input  logic       right,
    input  logic       GameArea,
    input  logic       retract,
    input  logic       retry,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_code,
    output logic [3:0] cmd_tile_x,
    output logic [3:0] cmd_tile_y,
    output logic [7:0] drop_cnt
);

    localparam int                c_HW        = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [c_HW-1:0]   c_HOLD_LOAD = c_HW'(HOLDOFF_CYCLES - 1);

    // ---------------------------------------------------------------
    // Button sampling and rise detection (rise is a registered pulse)
    // ---------------------------------------------------------------
    logic r_left_s, r_left_d, r_left_rise;
    logic r_right_s, r_right_d, r_right_rise;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_left_s     <= 1'b0;
            r_left_d     <= 1'b0;
            r_left_rise  <= 1'b0;
            r_right_s    <= 1'b0;
            r_right_d    <= 1'b0;
            r_right_rise <= 1'b0;
        end else begin
            r_left_s     <= left;
            r_left_d     <= r_left_s;
            r_left_rise  <= r_left_s & ~r_left_d;
            r_right_s    <= right;
            r_right_d    <= r_right_s;
            r_right_rise <= r_right_s & ~r_right_d;
        end
    end

    // ---------------------------------------------------------------
    // Cursor to tile mapping. The 11-bit difference keeps the sign so a
    // cursor left of / above the grid origin is rejected.
    // ---------------------------------------------------------------
    logic [10:0]        w_dx, w_dy, w_tx, w_ty;
    logic               w_move_ok;
    logic [c_CMD_W-1:0] w_move_cmd;

    assign w_dx       = {1'b0, ArrowPosX} - {1'b0, ORIGIN_X};
    assign w_dy       = {1'b0, ArrowPosY} - {1'b0, ORIGIN_Y};
    assign w_tx       = w_dx >> TILE_SHIFT;
    assign w_ty       = w_dy >> TILE_SHIFT;
    assign w_move_ok  = ~w_dx[10] & ~w_dy[10] &
                        (w_tx < 11'(GRID_W)) & (w_ty < 11'(GRID_H));
    assign w_move_cmd = pack_cmd(CMD_MOVE, w_tx[3:0], w_ty[3:0]);

    logic [c_ST_W-1:0] r_state;

`ifdef CLICK_REPEAT_EN
    localparam int              c_RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_RW-1:0] c_REP_LOAD = c_RW'(REPEAT_CYCLES - 1);

    logic            w_left_move;
    logic            w_rep_fire;
    logic            r_rep_move;
    logic [c_RW-1:0] r_rep_cnt;

    assign w_left_move = (r_state == c_ST_IDLE) & r_left_rise &
                         ~retry & ~retract & GameArea;
    assign w_rep_fire  = (r_state == c_ST_HOLD) & r_left_s & r_rep_move &
                         (r_rep_cnt == '0);

    // r_rep_move remembers that the press being held started as a MOVE;
    // it is cleared everywhere outside HOLD so other commands never repeat.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_rep_move <= 1'b0;
            r_rep_cnt  <= '0;
        end else if (w_left_move) begin
            r_rep_move <= 1'b1;
            r_rep_cnt  <= c_REP_LOAD;
        end else if (r_state != c_ST_HOLD) begin
            r_rep_move <= 1'b0;
        end else if (r_left_s && r_rep_move) begin
            if (r_rep_cnt == '0) begin
                r_rep_cnt <= c_REP_LOAD;
            end else begin
                r_rep_cnt <= r_rep_cnt - 1'b1;
            end
        end
    end
`endif

    // ---------------------------------------------------------------
    // Command build: left has priority over a same-cycle right rise.
    // ---------------------------------------------------------------
    logic               w_req_enq;
    logic [c_CMD_W-1:0] w_req_data;
    logic               w_bounds_drop;

    always_comb begin
        w_req_enq     = 1'b0;
        w_req_data    = '0;
        w_bounds_drop = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (r_left_rise) begin
                if (retry) begin
                    w_req_enq  = 1'b1;
                    w_req_data = pack_cmd(CMD_RESTART, 4'd0, 4'd0);
                end else if (retract) begin
                    w_req_enq  = 1'b1;
                    w_req_data = pack_cmd(CMD_UNDO, 4'd0, 4'd0);
                end else if (GameArea) begin
                    w_req_enq     = w_move_ok;
                    w_bounds_drop = ~w_move_ok;
                    w_req_data    = w_move_cmd;
                end
            end else if (r_right_rise) begin
                w_req_enq  = 1'b1;
                w_req_data = pack_cmd(CMD_CANCEL, 4'd0, 4'd0);
            end
        end
`ifdef CLICK_REPEAT_EN
        if (w_rep_fire) begin
            w_req_enq     = w_move_ok;
            w_bounds_drop = ~w_move_ok;
            w_req_data    = w_move_cmd;
        end
`endif
    end

    // ---------------------------------------------------------------
    // Click FSM with registered enqueue request
    // ---------------------------------------------------------------
    logic               r_enq;
    logic [c_CMD_W-1:0] r_enq_data;
    logic [c_HW-1:0]    r_hold_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_enq      <= 1'b0;
            r_enq_data <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_enq <= w_req_enq;
            if (w_req_enq) begin
                r_enq_data <= w_req_data;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (r_left_rise || r_right_rise) begin
                        r_state <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (!r_left_s && !r_right_s) begin
                        r_state    <= c_ST_LOCK;
                        r_hold_cnt <= c_HOLD_LOAD;
                    end
                end
                c_ST_LOCK: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------
    logic [c_CMD_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_deq;

    mouse_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_CMD_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (reset),
        .i_wr_en   (r_enq),
        .i_wr_data (r_enq_data),
        .i_rd_en   (cmd_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_deq      = ~w_empty & cmd_ready;
    assign cmd_valid  = ~w_empty;
    assign cmd_code   = w_head[9:8];
    assign cmd_tile_x = w_head[7:4];
    assign cmd_tile_y = w_head[3:0];

    // ---------------------------------------------------------------
    // Drop counter: out-of-grid MOVE and push into a full FIFO can land
    // in the same cycle, so the increment is two bits wide.
    // ---------------------------------------------------------------
    logic       w_full_drop;
    logic [1:0] w_drop_inc;
    logic [8:0] w_drop_sum;
    logic [7:0] r_drop_cnt;

    assign w_full_drop = r_enq & w_full & ~w_deq;
    assign w_drop_inc  = {1'b0, w_bounds_drop} + {1'b0, w_full_drop};
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mouse_click_cmd.sv
`default_nettype none
//==============================================================================
// Module   : tb_mouse_click_cmd
// Purpose  : Self-checking bench for mouse_click_cmd. Directed clicks push
//            their expected command into a scoreboard queue; a monitor
//            pops and compares on every accepted handshake.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mouse_click_cmd;
    import mouse_cmd_pkg::*;

    localparam int c_HOLD = 20;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] ArrowPosX = '0;
    logic [9:0] ArrowPosY = '0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       GameArea = 1'b0;
    logic       retract = 1'b0;
    logic       retry = 1'b0;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [1:0] cmd_code;
    logic [3:0] cmd_tile_x;
    logic [3:0] cmd_tile_y;
    logic [7:0] drop_cnt;

    mouse_click_cmd #(
        .ORIGIN_X       (10'd64),
        .ORIGIN_Y       (10'd32),
        .TILE_SHIFT     (5),
        .GRID_W         (12),
        .GRID_H         (12),
        .HOLDOFF_CYCLES (c_HOLD),
        .FIFO_DEPTH     (4),
        .REPEAT_CYCLES  (50)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .ArrowPosX  (ArrowPosX),
        .ArrowPosY  (ArrowPosY),
        .left       (left),
        .right      (right),
        .GameArea   (GameArea),
        .retract    (retract),
        .retry      (retry),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_tile_x (cmd_tile_x),
        .cmd_tile_y (cmd_tile_y),
        .drop_cnt   (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted head is compared with the queue.
    logic [9:0] mon_got;
    logic [9:0] mon_exp;
    initial begin
        forever begin
            @(negedge sys_clk);
            if (cmd_valid && cmd_ready) begin
                mon_got = {cmd_code, cmd_tile_x, cmd_tile_y};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_cmd: got %h expected none", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got == mon_exp) n_pass++;
                    else $display("FAIL cmd_compare: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic set_pos(input int x, input int y, input logic ga);
        ArrowPosX = 10'(x);
        ArrowPosY = 10'(y);
        GameArea  = ga;
    endtask

    task automatic settle();
        repeat (c_HOLD + 10) @(posedge sys_clk);
        #1;
    endtask

    task automatic click(input logic l, input logic r);
        @(posedge sys_clk); #1;
        left  = l;
        right = r;
        repeat (3) @(posedge sys_clk);
        #1;
        left  = 1'b0;
        right = 1'b0;
        settle();
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge sys_clk);
            t++;
        end
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int k;
    int first_valid;
    int n_valid;
    int d0;

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_code", int'(cmd_code), 0);
        chk("rst_tile_x", int'(cmd_tile_x), 0);
        chk("rst_tile_y", int'(cmd_tile_y), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        reset = 1'b0;

        // Latency: MOVE (1,1), valid first seen three cycles after sampling
        cmd_ready = 1'b1;
        set_pos(100, 70, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd1, 4'd1));
        @(posedge sys_clk); #1;
        left = 1'b1;
        k = cyc;
        first_valid = -1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (cmd_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
        end
        @(posedge sys_clk); #1;
        left = 1'b0;
        settle();
        chk("latency", first_valid, k + 4);
        chk("valid_cycles", n_valid, 1);

        // Region priority and button mapping
        retry = 1'b1; retract = 1'b1;
        exp_q.push_back(pack_cmd(CMD_RESTART, 4'd0, 4'd0));
        click(1'b1, 1'b0);
        retry = 1'b0;
        exp_q.push_back(pack_cmd(CMD_UNDO, 4'd0, 4'd0));
        click(1'b1, 1'b0);
        retract = 1'b0;
        exp_q.push_back(pack_cmd(CMD_CANCEL, 4'd0, 4'd0));
        click(1'b0, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd1, 4'd1));
        click(1'b1, 1'b1);
        chk("both_buttons_drop", int'(drop_cnt), 0);
        set_pos(100, 70, 1'b0);
        click(1'b1, 1'b0);
        chk("outside_regions_drop", int'(drop_cnt), 0);
        drain("drain_regions");

        // Grid bounds
        set_pos(40, 70, 1'b1);
        click(1'b1, 1'b0);
        chk("drop_neg_x", int'(drop_cnt), 1);
        set_pos(448, 100, 1'b1);
        click(1'b1, 1'b0);
        chk("drop_x_ge_w", int'(drop_cnt), 2);
        set_pos(100, 20, 1'b1);
        click(1'b1, 1'b0);
        chk("drop_neg_y", int'(drop_cnt), 3);
        set_pos(64, 32, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd0, 4'd0));
        click(1'b1, 1'b0);
        set_pos(447, 415, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd11, 4'd11));
        click(1'b1, 1'b0);
        chk("edge_tiles_drop", int'(drop_cnt), 3);
        drain("drain_bounds");

        // FIFO full: four held, fifth dropped
        cmd_ready = 1'b0;
        d0 = int'(drop_cnt);
        set_pos(64, 32, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd0, 4'd0));
        click(1'b1, 1'b0);
        set_pos(96, 32, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd1, 4'd0));
        click(1'b1, 1'b0);
        set_pos(64, 64, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd0, 4'd1));
        click(1'b1, 1'b0);
        set_pos(447, 415, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd11, 4'd11));
        click(1'b1, 1'b0);
        set_pos(100, 70, 1'b1);
        click(1'b1, 1'b0);
        chk("full_drop", int'(drop_cnt), d0 + 1);
        chk("full_valid", int'(cmd_valid), 1);
        chk("full_head", int'({cmd_code, cmd_tile_x, cmd_tile_y}), int'(pack_cmd(CMD_MOVE, 4'd0, 4'd0)));

        // Push and pop in the same cycle while full: both succeed
        set_pos(160, 128, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd3, 4'd3));
        @(posedge sys_clk); #1;
        left = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        cmd_ready = 1'b1;
        @(posedge sys_clk); #1;
        cmd_ready = 1'b0;
        left = 1'b0;
        settle();
        chk("full_enq_deq_drop", int'(drop_cnt), d0 + 1);
        cmd_ready = 1'b1;
        drain("drain_full");
        chk("drained_valid", int'(cmd_valid), 0);

        // Holdoff: a press during lockout is ignored, a later one accepted
        set_pos(100, 70, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd1, 4'd1));
        @(posedge sys_clk); #1;
        left = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        left = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        left = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        left = 1'b0;
        settle();
        chk("holdoff_pending", exp_q.size(), 0);
        set_pos(64, 64, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd0, 4'd1));
        click(1'b1, 1'b0);
        drain("drain_holdoff");

        // Reset with queued commands
        cmd_ready = 1'b0;
        set_pos(96, 32, 1'b1);
        click(1'b1, 1'b0);
        click(1'b1, 1'b0);
        click(1'b1, 1'b0);
        chk("pre_reset_valid", int'(cmd_valid), 1);
        @(posedge sys_clk); #1;
        reset = 1'b1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        chk("post_reset_valid", int'(cmd_valid), 0);
        chk("post_reset_drop", int'(drop_cnt), 0);
        cmd_ready = 1'b1;
        set_pos(100, 70, 1'b1);
        exp_q.push_back(pack_cmd(CMD_MOVE, 4'd1, 4'd1));
        click(1'b1, 1'b0);
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
